// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch control: request, capture, classify, then one PC-update strobe per
// instruction. Also owns halt/fault detection and the retired-instruction count.
module fetch_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        PCrst_i,
  output logic        imem_req_o,
  input  logic        imem_valid_i,
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  input  logic        br_taken_i,
  input  logic        stall_i,
  output logic        pc_en_o,
  output logic        BE_o,
  output logic        UJE_o,
  output logic        JALRE_o,
  output logic        reg_we_o,
  output logic        halt_o,
  output logic        fault_o,
  output logic [31:0] instret_o,
  output logic [2:0]  dbg_state_o
);

  // Handshake: imem_req_o stays high through FETCH and WAIT; an instruction is accepted
  // on any WAIT cycle where imem_valid_i is high, and instr_i is ignored otherwise.

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic [7:0]  r_wait_cnt;
  logic        r_halt;
  logic        r_fault;
  logic        w_capture;
  logic        w_clr_wait;
  logic        w_inc_wait;
  logic        w_legal;
  logic [7:0]  w_wait_inc;
  logic [6:0]  w_opcode;

  assign w_opcode   = r_instr[6:0];
  assign w_wait_inc = r_wait_cnt + 8'd1;

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_LUI,
      OP_AUIPC, OP_BRANCH, OP_JAL, OP_JALR: w_legal = 1'b1;
      default:                              w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_state    <= S_IDLE;
      r_instr    <= 32'h0000_0013;
      r_instret  <= 32'd0;
      r_wait_cnt <= 8'd0;
      r_halt     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_instr <= instr_i;
      if (w_clr_wait) r_wait_cnt <= 8'd0;
      else if (w_inc_wait) r_wait_cnt <= w_wait_inc;
      if (pc_en_o) r_instret <= r_instret + 32'd1;
      if (w_next == S_HALT) r_halt <= 1'b1;
      if (w_next == S_FAULT) r_fault <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_clr_wait = 1'b0;
    w_inc_wait = 1'b0;
    imem_req_o = 1'b0;
    pc_en_o    = 1'b0;
    BE_o       = 1'b0;
    UJE_o      = 1'b0;
    JALRE_o    = 1'b0;
    reg_we_o   = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        w_clr_wait = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        imem_req_o = 1'b1;
        // Valid beats a coincident timeout.
        if (imem_valid_i) begin
          w_capture = 1'b1;
          w_next    = S_DECODE;
        end else begin
          w_inc_wait = 1'b1;
          if (w_wait_inc == LP_MAX_WAIT) w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        if (w_opcode == OP_SYSTEM) w_next = S_HALT;
        else if (w_legal)          w_next = S_EXEC;
        else                       w_next = S_FAULT;
      end
      S_EXEC: begin
        if (!stall_i) begin
          pc_en_o  = 1'b1;
          w_next   = S_FETCH;
          BE_o     = (w_opcode == OP_BRANCH) && br_taken_i;
          UJE_o    = (w_opcode == OP_JAL);
          JALRE_o  = (w_opcode == OP_JALR);
          reg_we_o = (w_opcode != OP_BRANCH) && (w_opcode != OP_STORE);
        end
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  assign instr_o     = r_instr;
  assign instret_o   = r_instret;
  assign halt_o      = r_halt;
  assign fault_o     = r_fault;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a per-instruction transaction model:
// cycle budget, expected strobes/selects from the opcode rules, and retirement count.
module tb_fetch_sequencer;

  localparam int MAX_WAIT = 15;

  logic        clk_i = 1'b0;
  logic        PCrst_i;
  logic        imem_req_o;
  logic        imem_valid_i;
  logic [31:0] instr_i;
  logic [31:0] instr_o;
  logic        br_taken_i;
  logic        stall_i;
  logic        pc_en_o;
  logic        BE_o;
  logic        UJE_o;
  logic        JALRE_o;
  logic        reg_we_o;
  logic        halt_o;
  logic        fault_o;
  logic [31:0] instret_o;
  logic [2:0]  dbg_state_o;

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] model_instret = 32'd0;
  logic [31:0] exp_q[$];
  logic [6:0]  legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b0110111, 7'b0010111, 7'b1100011, 7'b1101111,
                                7'b1100111};

  fetch_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_i(clk_i), .PCrst_i(PCrst_i), .imem_req_o(imem_req_o),
    .imem_valid_i(imem_valid_i), .instr_i(instr_i), .instr_o(instr_o),
    .br_taken_i(br_taken_i), .stall_i(stall_i), .pc_en_o(pc_en_o),
    .BE_o(BE_o), .UJE_o(UJE_o), .JALRE_o(JALRE_o), .reg_we_o(reg_we_o),
    .halt_o(halt_o), .fault_o(fault_o), .instret_o(instret_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {BE, UJE, JALRE, reg_we} on the retiring cycle, from the opcode class rules
  function automatic logic [3:0] ref_sel(input logic [31:0] ins, input logic br);
    case (ins[6:0])
      7'b1100011: ref_sel = {br, 3'b000};
      7'b1101111: ref_sel = 4'b0101;
      7'b1100111: ref_sel = 4'b0011;
      7'b0100011: ref_sel = 4'b0000;
      default:    ref_sel = 4'b0001;
    endcase
  endfunction

  task automatic check_reset_values();
    check_val("rst_instr", instr_o, 32'h0000_0013);
    check_val("rst_instret", instret_o, 32'd0);
    check_val("rst_flags", {30'd0, halt_o, fault_o}, 32'd0);
    check_val("rst_strobes", {26'd0, imem_req_o, pc_en_o, BE_o, UJE_o, JALRE_o, reg_we_o}, 32'd0);
  endtask

  // Called just after a falling edge; returns with the DUT leaving IDLE on the next rise.
  task automatic reset_now();
    PCrst_i = 1'b0;
    #1;
    check_reset_values();
    model_instret = 32'd0;
    exp_q.delete();
    imem_valid_i = 1'b0;
    stall_i = 1'b0;
    @(negedge clk_i);
    check_reset_values();
    #2 PCrst_i = 1'b1;
    #1;
    check_val("idle_req", {31'd0, imem_req_o}, 32'd0);
  endtask

  // Driver for one instruction starting at FETCH; abort_at>0 fires reset in that cycle.
  task automatic do_instr(input logic [31:0] ins, input int n_wait, input int n_stall,
                          input logic br, input int abort_at);
    int total;
    total = 4 + n_wait + n_stall;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk_i);
      if (c == 2 + n_wait) imem_valid_i = 1'b1;
      else if (c > 2 + n_wait) imem_valid_i = 1'($urandom_range(0, 1));
      else imem_valid_i = 1'b0;
      instr_i = (c == 2 + n_wait) ? ins : $urandom;
      stall_i = (c >= 4 + n_wait && c < 4 + n_wait + n_stall) ? 1'b1 : 1'b0;
      br_taken_i = (c >= 4 + n_wait) ? br : 1'($urandom_range(0, 1));
      #1;
      check_val("imem_req", {31'd0, imem_req_o}, {31'd0, (c <= 2 + n_wait) ? 1'b1 : 1'b0});
      if (c == total) begin
        check_val("pc_en", {31'd0, pc_en_o}, 32'd1);
        check_val("selects", {28'd0, BE_o, UJE_o, JALRE_o, reg_we_o}, {28'd0, ref_sel(ins, br)});
        check_val("instr_o", instr_o, ins);
        model_instret = model_instret + 32'd1;
        exp_q.push_back(model_instret);
      end else begin
        check_val("quiet", {27'd0, pc_en_o, BE_o, UJE_o, JALRE_o, reg_we_o}, 32'd0);
      end
      if (c == abort_at) begin
        reset_now();
        return;
      end
    end
    @(posedge clk_i);
    #1;
    check_val("instret", instret_o, exp_q.pop_front());
  endtask

  task automatic do_except(input logic [31:0] ins, input logic is_halt);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      imem_valid_i = (c == 2) ? 1'b1 : 1'b0;
      instr_i = (c == 2) ? ins : $urandom;
      #1;
      check_val("exc_pc_en", {31'd0, pc_en_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    check_val("exc_flags", {30'd0, halt_o, fault_o}, {30'd0, is_halt, ~is_halt});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      imem_valid_i = 1'($urandom_range(0, 1));
      instr_i = $urandom;
      #1;
      check_val("exc_sticky", {30'd0, halt_o, fault_o}, {30'd0, is_halt, ~is_halt});
      check_val("exc_quiet", {26'd0, imem_req_o, pc_en_o, BE_o, UJE_o, JALRE_o, reg_we_o}, 32'd0);
      check_val("exc_instret", instret_o, model_instret);
    end
    reset_now();
  endtask

  task automatic do_timeout();
    for (int c = 1; c <= 1 + MAX_WAIT; c++) begin
      @(negedge clk_i);
      imem_valid_i = 1'b0;
      instr_i = $urandom;
      #1;
      check_val("to_pending", {31'd0, fault_o}, 32'd0);
      check_val("to_pc_en", {31'd0, pc_en_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    check_val("to_fault", {31'd0, fault_o}, 32'd1);
    @(negedge clk_i);
    imem_valid_i = 1'b1;
    #1;
    check_val("to_sticky", {30'd0, fault_o, imem_req_o}, 32'd2);
    check_val("to_instret", instret_o, model_instret);
    reset_now();
  endtask

  initial begin
    logic [31:0] rnd;
    PCrst_i = 1'b0;
    imem_valid_i = 1'b0;
    instr_i = 32'd0;
    br_taken_i = 1'b0;
    stall_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check_reset_values();
    #1 PCrst_i = 1'b1;

    do_instr(32'h0010_0093, 0, 0, 1'b0, 0);   // ADDI
    do_instr(32'h0000_0463, 0, 0, 1'b1, 0);   // BEQ taken
    do_instr(32'h0000_0463, 0, 0, 1'b0, 0);   // BEQ not taken
    do_instr(32'h0080_00EF, 0, 0, 1'b1, 0);   // JAL
    do_instr(32'h0000_80E7, 0, 0, 1'b1, 0);   // JALR
    do_instr(32'h0010_0093, 4, 0, 1'b0, 0);   // valid on 5th WAIT cycle
    do_instr(32'h0010_0093, 0, 3, 1'b1, 0);   // three stalled EXEC cycles
    do_instr(32'h0010_0093, MAX_WAIT - 1, 0, 1'b0, 0);  // valid on last WAIT cycle

    for (int i = 0; i < 30; i++) begin
      rnd = $urandom;
      do_instr({rnd[31:7], legal_ops[$urandom_range(0, 8)]},
               $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    do_instr(32'h0010_0093, 3, 0, 1'b0, 3);   // reset mid-WAIT
    do_instr(32'h0010_0093, 0, 3, 1'b0, 5);   // reset mid-stalled EXEC
    do_instr(32'h0080_00EF, 1, 1, 1'b0, 0);

    do_except(32'h0000_007F, 1'b0);           // illegal opcode
    do_instr(32'h0010_0093, 0, 0, 1'b0, 0);
    do_except(32'h0000_0073, 1'b1);           // ECALL
    do_timeout();
    do_instr(32'h0000_0463, 2, 2, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle control sequencer for the fetch datapath. It requests each instruction from instruction memory at the current PC and captures it. It then classifies the opcode and issues exactly one PC-update strobe per instruction, with the branch, JAL or JALR select that the fetch unit consumes. It sits between instruction memory, the decoder/ALU (branch comparator) and the PC register. It also owns halt/fault detection and the retired-instruction count.

## Interface
Parameters:
- MAX_WAIT, default 15: cycles spent in WAIT without imem_valid_i before FAULT (range 1..255).

Ports:
- clk_i  input  1  clock, rising edge.
- PCrst_i  input  1  reset, asynchronous, active-low.
- imem_req_o  output  1  instruction request at current PC.
- imem_valid_i  input  1  instr_i valid this cycle.
- instr_i  input  32  instruction word from memory.
- instr_o  output  32  latched instruction to decoder/immediate generator.
- br_taken_i  input  1  branch comparator result, sampled in EXEC only.
- stall_i  input  1  downstream hold; freezes EXEC.
- pc_en_o  output  1  PC register update strobe; the PC holds when low.
- BE_o  output  1  branch-taken select (PC += imm<<1).
- UJE_o  output  1  JAL select (PC += imm<<1, rd = PC+4).
- JALRE_o  output  1  JALR select (PC = rs1 + imm, rd = PC+4).
- reg_we_o  output  1  register-file write enable for rd.
- halt_o  output  1  sticky; ECALL/EBREAK reached.
- fault_o  output  1  sticky; illegal opcode or memory timeout.
- instret_o  output  32  count of retired instructions.

## Operation
- States (3-bit): IDLE, FETCH, WAIT, DECODE, EXEC, HALT, FAULT.
- IDLE: reset state. It moves to FETCH on the first clock edge after reset deasserts.
- FETCH: imem_req_o=1. Clears the wait counter. Next state is WAIT.
- WAIT: imem_req_o=1.
  - imem_valid_i=1: instr_o <= instr_i and go to DECODE.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT it goes to FAULT.
  - Valid and timeout on the same cycle: valid wins.
- DECODE: classifies instr_o[6:0].
  - 1110011 -> HALT.
  - Any opcode not in {0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1100011, 1101111, 1100111} -> FAULT.
  - Otherwise -> EXEC.
- EXEC with stall_i=1: all strobes 0 and the state holds.
- EXEC with stall_i=0: pc_en_o=1, instret_o increments (wraps at 2^32), then go to FETCH.
  - 1100011: BE_o=br_taken_i.
  - 1101111: UJE_o=1.
  - 1100111: JALRE_o=1.
  - Any other opcode: all selects 0, so PC += 4.
  - reg_we_o=1 for every class except 1100011 and 0100011.
- The selects are one-hot or all-zero. They are combinational from state, instr_o, br_taken_i and stall_i, and are only ever nonzero while pc_en_o=1.
- HALT: halt_o=1, no requests, no strobes. Held until reset.
- FAULT: fault_o=1, no requests, no strobes. Held until reset.

## Timing
- Reset values:
  - state IDLE.
  - instr_o=32'h00000013.
  - instret_o=0.
  - halt_o=0, fault_o=0.
  - Wait counter 0.
  - All strobes and imem_req_o are 0.
- Assertion of PCrst_i takes effect immediately, in any state, including mid-WAIT or a stalled EXEC. Outputs go to reset values without waiting for a clock edge.
- Cycle budget: minimum 4 cycles per instruction (FETCH, WAIT with valid, DECODE, EXEC).
  - Each cycle without valid adds 1.
  - Each stalled cycle adds 1.
- imem_req_o is high in FETCH and WAIT only. instr_i is ignored in all other states.
- pc_en_o is high for exactly one cycle per retired instruction. instret_o updates on that same edge.
- halt_o and fault_o are registered. They rise on the edge that enters HALT or FAULT.

## Test plan
- Reset then ADDI (32'h00100093), valid on the first WAIT cycle:
  - pc_en_o pulses in cycle 4 after IDLE exit, with BE_o=UJE_o=JALRE_o=0 and reg_we_o=1.
  - instret_o=1.
- BEQ (32'h00000463):
  - br_taken_i=1: BE_o=1, reg_we_o=0.
  - Repeated with br_taken_i=0: no selects, pc_en_o=1.
- JAL (32'h008000EF) and JALR (32'h000080E7):
  - UJE_o=1 and JALRE_o=1 respectively, one-hot.
  - reg_we_o=1, one pc_en_o pulse each.
- Memory latency and stall:
  - Valid after 5 WAIT cycles: retires in 8 cycles.
  - MAX_WAIT=15 with valid never asserted: fault_o=1 after 15 WAIT cycles, no pc_en_o.
  - stall_i held 3 cycles in EXEC: pc_en_o delayed exactly 3 cycles.
- Exceptional opcodes:
  - Opcode 7'b1111111 -> fault_o=1 after DECODE.
  - ECALL 32'h00000073 -> halt_o=1. Both are sticky and instret_o stays unchanged.
- Async reset asserted mid-WAIT and mid-stalled EXEC:
  - All outputs go to reset values immediately, and instret_o=0.
  - After release, the normal sequence resumes from IDLE.
